rgb_led_arbiter: RTL

Time-slicing arbiter that shares the board's 3-bit RGB LED among up to N_REQ requesters (status, heartbeat, key feedback, etc.). Each requester presents a colour and a request. The arbiter grants one owner at a time, in round-robin order, for a fixed hold time measured in prescaled ticks. It sits between the requester logic and the RGB_LED pins and is the only driver of those pins.

---
 rtl/led_arb_pkg.sv | 17 +
 rtl/led_tick_gen.sv | 38 +++
 rtl/rgb_led_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/led_arb_pkg.sv
// Shared types and constants for the RGB LED arbiter.
package led_arb_pkg;

  // Width of one RGB colour word (one bit per LED channel).
  localparam int LED_W = 3;

  // Largest supported requester count.
  localparam int MAX_N_REQ = 8;

  // Arbiter states: no owner, LED owned, one-cycle blank separation.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: emits a one-cycle tick every TICK_DIV clocks.
// A synchronous clear restarts the count so the first tick comes
// exactly TICK_DIV cycles after the clear is released.
module led_tick_gen #(
  parameter int TICK_DIV = 24_000_000
) (
  input  logic CLK_IN,
  input  logic RST_N,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: wrap to zero at the terminal value.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end
  end

  // Count register with reset and synchronous clear.
  always_ff @(posedge CLK_IN) begin
    if (!RST_N || clear_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/rgb_led_arbiter.sv
// Round-robin time-slicing arbiter for the board RGB LED.
// Grants one requester at a time for HOLD_TICKS prescaled ticks, with a
// one-cycle blank gap between different owners.
// Optional build macro: LED_ARB_BLINK_EN makes the granted colour blink,
// toggling on every tick of the slot.
module rgb_led_arbiter
  import led_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int TICK_DIV   = 24_000_000,
  parameter int HOLD_TICKS = 2
) (
  input  logic                   CLK_IN,
  input  logic                   RST_N,
  input  logic [N_REQ-1:0]       req,
  input  logic [LED_W*N_REQ-1:0] color,
  output logic [N_REQ-1:0]       grant,
  output logic [LED_W-1:0]       RGB_LED,
  output logic                   busy
);

  localparam int OWN_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [OWN_W-1:0]  OWN_RST   = OWN_W'(N_REQ - 1);

  arb_state_t         state_q;
  logic [OWN_W-1:0]   owner_q;
  logic [OWN_W-1:0]   last_owner_q;
  logic [N_REQ-1:0]   grant_q;
  logic [LED_W-1:0]   rgb_q;
  logic               busy_q;
  logic [HOLD_W-1:0]  hold_q;

  logic               tick;
  logic               tick_clr;
  logic               own_req;
  logic               others_pend;
  logic               any_req;
  logic               hold_done;
  logic               slot_end;
  logic               restart;
  logic               led_off;
  logic [OWN_W-1:0]   pick_idx;
  logic [N_REQ-1:0]   pick_onehot;
  logic [LED_W-1:0]   own_color;
  logic [LED_W-1:0]   pick_color;

  // First requester found scanning upward from the one after the last owner.
  function automatic logic [OWN_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [OWN_W-1:0] last);
    int idx;
    rr_pick = last;
    // Scan farthest-first so the nearest candidate overwrites the result.
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % N_REQ;
      if (r[idx]) begin
        rr_pick = OWN_W'(idx);
      end
    end
  endfunction

  led_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .CLK_IN (CLK_IN),
    .RST_N  (RST_N),
    .clear_i(tick_clr),
    .tick_o (tick)
  );

  // One-hot decode of the round-robin winner.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_pick_dec
    assign pick_onehot[gi] = (pick_idx == OWN_W'(gi));
  end

  // Slot bookkeeping: winner, release/expiry detection, prescaler clear.
  always_comb begin
    any_req     = |req;
    pick_idx    = rr_pick(req, last_owner_q);
    pick_color  = color[int'(pick_idx)*LED_W +: LED_W];
    own_color   = color[int'(owner_q)*LED_W +: LED_W];
    own_req     = req[owner_q];
    others_pend = |(req & ~grant_q);
    hold_done   = tick && (hold_q == HOLD_LAST);
    slot_end    = !own_req || hold_done;
    // Expiry with only the owner still asking re-arms the slot in place.
    restart     = (state_q == GRANT) && hold_done && own_req && !others_pend;
    // Prescaler runs only inside a slot, so entry always starts at zero.
    tick_clr    = (state_q != GRANT) || restart;
  end

`ifdef LED_ARB_BLINK_EN
  logic phase_q;

  // Blink phase: toggles on each tick of a grant, zero at every grant entry.
  always_ff @(posedge CLK_IN) begin
    if (!RST_N || state_q != GRANT) begin
      phase_q <= 1'b0;
    end else if (tick) begin
      phase_q <= ~phase_q;
    end
  end

  // Phase that will be in force next cycle, matching the registered LED.
  assign led_off = phase_q ^ tick;
`else
  assign led_off = 1'b0;
`endif

  // Arbiter FSM with registered grant, LED and busy outputs.
  always_ff @(posedge CLK_IN) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= OWN_RST;
      grant_q      <= '0;
      rgb_q        <= '0;
      busy_q       <= 1'b0;
      hold_q       <= '0;
    end else begin
      case (state_q)
        GRANT: begin
          if (slot_end) begin
            if (restart) begin
              hold_q <= '0;
              rgb_q  <= led_off ? '0 : own_color;
            end else begin
              state_q <= others_pend ? GAP : IDLE;
              grant_q <= '0;
              rgb_q   <= '0;
              busy_q  <= 1'b0;
              hold_q  <= '0;
            end
          end else begin
            if (tick) begin
              hold_q <= hold_q + HOLD_W'(1);
            end
            rgb_q <= led_off ? '0 : own_color;
          end
        end
        default: begin
          // IDLE and GAP both start a fresh slot for the round-robin winner.
          if (any_req) begin
            state_q      <= GRANT;
            owner_q      <= pick_idx;
            last_owner_q <= pick_idx;
            grant_q      <= pick_onehot;
            rgb_q        <= pick_color;
            busy_q       <= 1'b1;
            hold_q       <= '0;
          end else begin
            state_q <= IDLE;
            grant_q <= '0;
            rgb_q   <= '0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
          end
        end
      endcase
    end
  end

  assign grant   = grant_q;
  assign RGB_LED = rgb_q;
  assign busy    = busy_q;

endmodule
